// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and index-width helper.
package arb_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StFetch   = 2'd1,
      StLoad    = 2'd2,
      StPresent = 2'd3
   } arb_state_e;

   // Bits needed to index n items; never less than 1 so a 1-channel index stays legal.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first set bit of i_nonempty strictly after i_last, wrapping to 0.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = clog2(NCH)
) (
   input  logic [NCH-1:0] i_nonempty,
   input  logic [CW-1:0]  i_last,
   output logic           o_hit,
   output logic [CW-1:0]  o_idx
);

   logic          w_hit_hi;
   logic          w_hit_lo;
   logic [CW-1:0] w_idx_hi;
   logic [CW-1:0] w_idx_lo;

   // Channels above i_last are searched before the wrapped ones; scanning downwards lets
   // the lowest index in each half overwrite higher ones.
   always_comb begin
      w_hit_hi = 1'b0;
      w_hit_lo = 1'b0;
      w_idx_hi = '0;
      w_idx_lo = '0;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         if (i_nonempty[k]) begin
            if (CW'(k) > i_last) begin
               w_hit_hi = 1'b1;
               w_idx_hi = CW'(k);
            end else begin
               w_hit_lo = 1'b1;
               w_idx_lo = CW'(k);
            end
         end
      end
   end

   assign o_hit = w_hit_hi | w_hit_lo;
   assign o_idx = w_hit_hi ? w_idx_hi : w_idx_lo;

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NCH upstream FIFOs onto one channel-tagged valid/ready stream.
module fifo_rr_drain
   import arb_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = 8,
   parameter int unsigned AW  = 3,
   parameter int unsigned CW  = clog2(NCH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*AW-1:0] fifo_records,
   input  logic [NCH*DW-1:0] fifo_rdata,
   output logic [NCH-1:0]    fifo_re,
   output logic [DW-1:0]     out_data,
   output logic [CW-1:0]     out_chan,
   output logic              out_valid,
   input  logic              out_ready
);

   if (NCH < 2 || NCH > 8) begin : g_bad_nch
      $error("fifo_rr_drain: NCH must be in 2..8");
   end

   arb_state_e    r_state;
   arb_state_e    w_state_next;
   logic [CW-1:0] r_grant;
   logic [CW-1:0] w_grant_next;
   logic [CW-1:0] r_last;
   logic [CW-1:0] w_last_next;
   logic [DW-1:0] r_out_data;
   logic [DW-1:0] w_data_next;
   logic [CW-1:0] r_out_chan;
   logic [CW-1:0] w_chan_next;
   logic          r_out_valid;
   logic          w_valid_next;

   logic [NCH-1:0] w_nonempty;
   logic           w_hit;
   logic [CW-1:0]  w_pick_idx;
   logic [DW-1:0]  w_sel_data;

   always_comb begin
      w_nonempty = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         w_nonempty[k] = |fifo_records[k*AW +: AW];
      end
   end

   rr_pick #(
      .NCH (NCH),
      .CW  (CW)
   ) u_rr_pick (
      .i_nonempty (w_nonempty),
      .i_last     (r_last),
      .o_hit      (w_hit),
      .o_idx      (w_pick_idx)
   );

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (r_grant == CW'(k)) w_sel_data = fifo_rdata[k*DW +: DW];
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last;
      w_data_next  = r_out_data;
      w_chan_next  = r_out_chan;
      w_valid_next = r_out_valid;
      case (r_state)
         StIdle: begin
            if (w_hit) begin
               w_grant_next = w_pick_idx;
               w_state_next = StFetch;
            end
         end
         StFetch: begin
            w_state_next = StLoad;
         end
         StLoad: begin
            // rdata reflects the pop issued in FETCH from this cycle on.
            w_data_next  = w_sel_data;
            w_chan_next  = r_grant;
            w_valid_next = 1'b1;
            w_state_next = StPresent;
         end
         StPresent: begin
            if (r_out_valid && out_ready) begin
               w_valid_next = 1'b0;
               w_last_next  = r_grant;
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_grant     <= '0;
         r_last      <= CW'(NCH - 1);
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_grant     <= w_grant_next;
         r_last      <= w_last_next;
         r_out_data  <= w_data_next;
         r_out_chan  <= w_chan_next;
         r_out_valid <= w_valid_next;
      end
   end

   // Read enable comes only from registered state so it can never glitch on input changes.
   always_comb begin
      fifo_re = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (r_state == StFetch && r_grant == CW'(k)) fifo_re[k] = 1'b1;
      end
   end

   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_valid = r_out_valid;

endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin drain stage sitting directly downstream of a bank of `NCH` `fifo` instances. It watches each FIFO's `records` count, issues single-cycle `re` pulses to the selected non-empty FIFO, captures the FIFO's registered `rdata`, and presents one word at a time on a valid/ready output stream tagged with the source channel. It is the arbitration point of the design: fair service across channels, and no FIFO is ever read while empty.

## Interface
- `NCH`, 4, number of upstream FIFO channels (2..8)
- `DW`, 8, data width; must match the upstream FIFOs
- `AW`, 3, FIFO address width; must match `records` width upstream
- `CW`, `$clog2(NCH)`, channel-index width (derived, not overridden)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `fifo_records`  in  NCH*AW  packed per-channel `records`; channel k at [k*AW +: AW]
- `fifo_rdata`  in  NCH*DW  packed per-channel `rdata`; channel k at [k*DW +: DW]
- `fifo_re`  out  NCH  per-channel read enable; at most one bit set
- `out_data`  out  DW  word being presented
- `out_chan`  out  CW  source channel of `out_data`
- `out_valid`  out  1  `out_data`/`out_chan` valid
- `out_ready`  in  1  consumer accepts when high with `out_valid`

## Operation
- FSM states: IDLE, FETCH, LOAD, PRESENT.
- IDLE: search channels starting at `last+1` (mod NCH), wrapping, for the first with `records != 0`. On a hit, latch it in `grant` and go to FETCH. With no hit, stay in IDLE.
- FETCH: `fifo_re[grant]`=1 for exactly this one cycle, then go to LOAD. `fifo_re` is decoded from registered state/grant only, never from inputs.
- LOAD: `out_data <= fifo_rdata[grant]`, `out_chan <= grant`, `out_valid <= 1`, then go to PRESENT.
- PRESENT: hold `out_data`/`out_chan`/`out_valid` stable. On `out_valid && out_ready`: `out_valid <= 0`, `last <= grant`, go to IDLE.
- Reset values: state IDLE, `fifo_re`=0, `out_valid`=0, `out_data`=0, `out_chan`=0, `grant`=0, `last`=NCH-1 (channel 0 has first priority).
- Boundary conditions:
  - Upstream writes arriving during any state are harmless. The arbiter is the sole reader, so a granted channel cannot become empty before FETCH.
  - A single non-empty channel is granted repeatedly.
  - All channels empty: remain in IDLE, no `re`.
  - `out_ready` held low: PRESENT persists indefinitely, and no further `re` is issued.
  - `reset` in any state returns to reset values at the next edge. `fifo_re` is 0 in the cycle after reset is sampled. A word already popped but not handed off is discarded.
- Index arithmetic is modulo NCH on `CW` bits. For non-power-of-two NCH, `last+1` wraps explicitly at NCH-1 to 0.

## Timing
- Edge e0: IDLE sees non-empty channel k. During e0→e1, state is FETCH and `fifo_re[k]`=1.
- Edge e1: FIFO pops and its `rdata` is valid after e1. During e1→e2, state is LOAD.
- Edge e2: `out_valid`=1 and `out_data` equals the popped word.
- Minimum 4 cycles per word with `out_ready` tied high: IDLE, FETCH, LOAD, PRESENT.
- Handshake completes at the first edge where `out_valid && out_ready`. `out_ready` may toggle freely; it is not a function of `out_valid`.

## Structure
- Shared package `arb_pkg`: state enum (IDLE/FETCH/LOAD/PRESENT, 2-bit encoding), and a `clog2` helper/constant for `CW`.
- Sub-module `rr_pick`: combinational rotate-priority search. Inputs: NCH-bit non-empty vector and `last`. Outputs: `hit` and `idx`. It is reused by the later multi-master arbiter.
- Top-level owns the FSM, the output registers and the `fifo_re` decode.

## Test plan
- Reset with all FIFOs empty for 20 cycles -> `fifo_re`=0 and `out_valid`=0 throughout.
- Channel 2 `records`=1 with `rdata`=8'hA5 at e1, `out_ready`=1 -> `fifo_re`=4'b0100 for exactly one cycle, then `out_valid` two edges later with `out_data`=8'hA5 and `out_chan`=2.
- All four channels with `records`=3, `out_ready`=1 -> grant order 0,1,2,3,0,1,... with a word every 4 cycles, and no channel read while `records`=0.
- `out_ready`=0 for 10 cycles during PRESENT -> `out_data`/`out_chan` stable, `out_valid`=1, no `re`. The word is accepted on the first `out_ready`=1 edge.
- `reset` asserted in FETCH and again in PRESENT -> next cycle `fifo_re`=0 and `out_valid`=0. After release, channel 0 is serviced first if it is non-empty.
- NCH=3, only channels 0 and 2 non-empty -> alternating 0,2,0,2 with the wrap from 2 to 0 correct.
